// File: rtl/amp_i2c_master.sv
// amp_i2c_master: single-register I2C master for the amplifier control bus.
// One accepted start runs a full write or read transaction.
//
// state    | meaning
// ---------|--------------------------------------------------
// IDLE     | bus released, waiting for start
// START    | START condition, 2 quarters
// ADDR_W   | sending {dev_addr,0}
// ACK_AW   | slave ACK after write address
// REG      | sending register pointer
// ACK_REG  | slave ACK after register pointer
// DATA     | sending write data
// ACK_DATA | slave ACK after write data
// RSTART   | repeated START, 3 quarters
// ADDR_R   | sending {dev_addr,1}
// ACK_AR   | slave ACK after read address
// READ     | shifting in 8 data bits
// MACK     | master NACK after read data
// STOP     | STOP condition, 3 quarters
module amp_i2c_master #(
  parameter int QDIV = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       amp_i2c_scl,
  input  logic       amp_i2c_sdai,
  output logic       amp_i2c_sdao
);

  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_AW, S_REG, S_ACK_REG, S_DATA, S_ACK_DATA,
    S_RSTART, S_ADDR_R, S_ACK_AR, S_READ, S_MACK, S_STOP
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt, qcnt_n;
  logic [1:0]      quarter, quarter_n;
  logic [2:0]      bitn, bitn_n;
  logic            rw_l;
  logic [6:0]      dev_l;
  logic [7:0]      reg_l, wd_l, rx;
  logic            smp;

  logic            tick, last_q, is_byte, is_ack, state_end, accept;
  logic            scl_n, sda_n, done_n;
  logic [7:0]      txbyte;

  // Quarter/bit sequencing, next-state selection and next bus levels.
  always_comb begin
    state_n   = state;
    qcnt_n    = qcnt;
    quarter_n = quarter;
    bitn_n    = bitn;
    scl_n     = 1'b1;
    sda_n     = 1'b1;
    txbyte    = 8'hFF;

    tick    = (qcnt == QW'(QDIV - 1));
    is_byte = (state == S_ADDR_W) || (state == S_REG) || (state == S_DATA) ||
              (state == S_ADDR_R) || (state == S_READ);
    is_ack  = (state == S_ACK_AW) || (state == S_ACK_REG) ||
              (state == S_ACK_DATA) || (state == S_ACK_AR);
    case (state)
      S_START:          last_q = (quarter == 2'd1);
      S_RSTART, S_STOP: last_q = (quarter == 2'd2);
      default:          last_q = (quarter == 2'd3);
    endcase
    state_end = tick && last_q && (!is_byte || (bitn == 3'd7));
    accept    = start && (state == S_IDLE);

    if (state == S_IDLE) begin
      qcnt_n    = '0;
      quarter_n = 2'd0;
      bitn_n    = 3'd0;
      if (accept) state_n = S_START;
    end else begin
      if (tick) begin
        qcnt_n = '0;
        if (last_q) begin
          quarter_n = 2'd0;
          if (is_byte) bitn_n = bitn + 3'd1;
        end else begin
          quarter_n = quarter + 2'd1;
        end
      end else begin
        qcnt_n = qcnt + 1'b1;
      end
      if (state_end) begin
        bitn_n = 3'd0;
        case (state)
          S_START:    state_n = S_ADDR_W;
          S_ADDR_W:   state_n = S_ACK_AW;
          S_ACK_AW:   state_n = smp ? S_STOP : S_REG;
          S_REG:      state_n = S_ACK_REG;
          S_ACK_REG:  state_n = smp ? S_STOP : (rw_l ? S_RSTART : S_DATA);
          S_DATA:     state_n = S_ACK_DATA;
          S_ACK_DATA: state_n = S_STOP;
          S_RSTART:   state_n = S_ADDR_R;
          S_ADDR_R:   state_n = S_ACK_AR;
          S_ACK_AR:   state_n = smp ? S_STOP : S_READ;
          S_READ:     state_n = S_MACK;
          S_MACK:     state_n = S_STOP;
          S_STOP:     state_n = S_IDLE;
          default:    state_n = S_IDLE;
        endcase
      end
    end

    case (state_n)
      S_ADDR_W: txbyte = {dev_l, 1'b0};
      S_REG:    txbyte = reg_l;
      S_DATA:   txbyte = wd_l;
      S_ADDR_R: txbyte = {dev_l, 1'b1};
      default:  txbyte = 8'hFF;
    endcase

    case (state_n)
      S_IDLE: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end
      S_START: begin
        scl_n = 1'b1;
        sda_n = (quarter_n == 2'd0);
      end
      S_ADDR_W, S_REG, S_DATA, S_ADDR_R: begin
        scl_n = quarter_n[1];
        sda_n = txbyte[3'd7 - bitn_n];
      end
      S_RSTART: begin
        scl_n = (quarter_n != 2'd0);
        sda_n = (quarter_n != 2'd2);
      end
      S_STOP: begin
        scl_n = (quarter_n != 2'd0);
        sda_n = (quarter_n == 2'd2);
      end
      default: begin
        scl_n = quarter_n[1];
        sda_n = 1'b1;
      end
    endcase

    done_n = (state_n == S_STOP) && (quarter_n == 2'd2) && (qcnt_n == QW'(QDIV - 1));
  end

  // State/counter registers, latched command, sampled bus data and registered outputs.
  // SDA follows SCL by one clk whenever SCL toggles, so the two never move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      qcnt         <= '0;
      quarter      <= 2'd0;
      bitn         <= 3'd0;
      rw_l         <= 1'b0;
      dev_l        <= 7'd0;
      reg_l        <= 8'd0;
      wd_l         <= 8'd0;
      rx           <= 8'd0;
      smp          <= 1'b0;
      amp_i2c_scl  <= 1'b1;
      amp_i2c_sdao <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      ack_err      <= 1'b0;
      rdata        <= 8'd0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      quarter <= quarter_n;
      bitn    <= bitn_n;
      if (accept) begin
        rw_l    <= rw;
        dev_l   <= dev_addr;
        reg_l   <= reg_addr;
        wd_l    <= wdata;
        ack_err <= 1'b0;
      end
      if (tick && (quarter == 2'd2)) begin
        smp <= amp_i2c_sdai;
        if (state == S_READ) rx <= {rx[6:0], amp_i2c_sdai};
      end
      if (state_end && is_ack && smp) ack_err <= 1'b1;
      if (state_end && (state == S_MACK)) rdata <= rx;
      amp_i2c_scl <= scl_n;
      if (scl_n == amp_i2c_scl) amp_i2c_sdao <= sda_n;
      busy <= (state_n != S_IDLE);
      done <= done_n;
    end
  end

endmodule

// File: doc/amp_i2c_master.md
# amp_i2c_master

I2C bus master that drives the amplifier control interface (`amp_i2c_scl`, `amp_i2c_sdai`, `amp_i2c_sdao`) of the toI2S top level. A single-cycle command performs one complete single-register transaction on the amplifier bus: a write (START, address+W, register, data, STOP) or a read (START, address+W, register, repeated START, address+R, data, NACK, STOP). It is the counterpart of the existing I2C slave interface: that block responds to the host, while this block initiates transfers toward the amplifier. It sits beside the register bank, which supplies its command fields.

## Interface
Parameters:
- `QDIV`, default 30: `clk` cycles per quarter SCL period. Minimum 2. The default gives 100 kHz from 12 MHz.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle command strobe. It is ignored while `busy`=1.
- `rw` in 1: 0 selects write, 1 selects read. Latched on an accepted `start`.
- `dev_addr` in 7: 7-bit slave address. Latched on an accepted `start`.
- `reg_addr` in 8: register pointer. Latched on an accepted `start`.
- `wdata` in 8: write data. Latched on an accepted `start`.
- `rdata` out 8: read data. Valid from `done` until the next accepted `start`.
- `busy` out 1: high while a transaction is in progress.
- `done` out 1: one-cycle pulse when a transaction ends.
- `ack_err` out 1: set when the slave NACKs. Valid with `done`; cleared on the next accepted `start`.
- `amp_i2c_scl` out 1: SCL level. 1 releases the line (pulled up), 0 drives it low.
- `amp_i2c_sdai` in 1: SDA line as sampled from the bus.
- `amp_i2c_sdao` out 1: SDA drive. 1 releases the line, 0 pulls it low. The pad and pull-up are handled at a higher level.

## Operation
- A quarter-tick counter runs from 0 to QDIV-1. Each wrap advances the quarter phase.
- Bit slot: 4 quarters.
  - Q0 and Q1: SCL=0. SDA is updated at the start of Q0.
  - Q2 and Q3: SCL=1. SDA is sampled on the last `clk` of Q2.
- START: 2 quarters.
  - SCL=1, SDA=1.
  - SCL=1, SDA=0.
- Repeated START: 3 quarters.
  - SCL=0, SDA=1.
  - SCL=1, SDA=1.
  - SCL=1, SDA=0.
- STOP: 3 quarters.
  - SCL=0, SDA=0.
  - SCL=1, SDA=0.
  - SCL=1, SDA=1.
- Bytes are sent MSB first. During each ACK slot the master releases SDA (sdao=1) and samples it; a sampled 1 is a NACK.
- States:
  - IDLE → START on an accepted `start`.
  - START → ADDR_W (`{dev_addr,0}`) → ACK → REG → ACK.
  - Write path: DATA → ACK → STOP.
  - Read path: RSTART → ADDR_R (`{dev_addr,1}`) → ACK → READ (shifts in 8 bits) → MACK (master sends 1 = NACK) → STOP.
  - STOP → IDLE. `done` pulses on the last cycle of STOP.
- NACK in any ACK slot: set `ack_err` and go straight to STOP. Remaining bytes are not sent.
- `rdata` is updated only on a read that completes without error.
- No clock stretching, no arbitration, no multi-master support. SCL is never read back.

## Timing
- Reset values:
  - `amp_i2c_scl`=1, `amp_i2c_sdao`=1.
  - `busy`=0, `done`=0, `ack_err`=0, `rdata`=0x00.
  - State IDLE, counters 0.
  - Reset takes effect immediately (asynchronous), including mid-transfer. The bus is released with no STOP generated.
- A `start` is accepted when it is sampled with `busy`=0. `busy`=1 from the next cycle.
- `done` asserts exactly N·QDIV cycles after the accepted `start` cycle:
  - Write: N = 113, i.e. 2 + 27·4 + 3.
  - Read: N = 152, i.e. 2 + 18·4 + 3 + 18·4 + 3.
  - NACK at address: N = 2 + 9·4 + 3 = 41.
- `busy` falls in the cycle after `done`. A new `start` in that cycle is accepted.
- `start` asserted on the same cycle as `done` is ignored.
- All outputs are registered. SCL and SDA never change in the same `clk` cycle, except at reset.

## Test plan
- **Write.** With QDIV=4 and a slave model that ACKs: `start`, rw=0, dev 0x2C, reg 0x03, data 0xA5.
  - Bus decodes as START, 0x58 (ACK), 0x03 (ACK), 0xA5 (ACK), STOP.
  - `done` at cycle 452; `ack_err`=0.
- **Read.** Slave returns 0x5A: rw=1, dev 0x2C, reg 0x10.
  - Bus decodes as 0x58, 0x10, Sr, 0x59, 0x5A, master NACK, STOP.
  - `rdata`=0x5A; `done` at cycle 608.
- **Address NACK.** Slave absent: STOP follows the 9th SCL pulse.
  - `done` at cycle 164, `ack_err`=1, `rdata` unchanged.
- **Start while busy.** A second `start` at cycle 50 of a write is ignored.
  - Exactly one transaction is seen on the bus and exactly one `done` pulse.
- **Reset mid-transfer.** `reset` asserted during the REG byte.
  - scl=sdao=1 and busy=0 within the same cycle.
  - A subsequent write completes normally.
- **Back-to-back.** `start` issued in the cycle after `done`.
  - Second START begins with no gap beyond the required 2-quarter START; both transactions decode correctly.
